ringlwe_decryptor: RTL and testbench

Streaming Binary Ring-LWE decryption engine: the receive end of the RingLWE encryption path. Holds the private key r2, accepts ciphertext coefficient pairs (c1_i, c2_i) over a valid/ready stream, and emits decoded message coefficients m_i = (c1_i·r2 + c2_i) mod Q over a second valid/ready stream. It also assembles the full decoded polynomial. It sits between the ciphertext transport and the message sink.

---
 rtl/ringlwe_pkg.sv | 41 ++++
 rtl/ringlwe_coef_mac.sv | 18 +
 rtl/ringlwe_decryptor.sv | 156 +++++++++++++++
 tb/tb_ringlwe_decryptor.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ringlwe_pkg.sv
// ringlwe_pkg
// Types, default sizes and the coefficient arithmetic shared by the Ring-LWE
// encryption and decryption blocks.
//   RLWE_N       : coefficients per polynomial
//   RLWE_Q       : coefficient width in bits, also the arithmetic modulus
//   coef_t       : one coefficient
//   poly_t       : one polynomial, index i at [i]
//   state_t      : decryptor control states
//   coef_mac_mod : (c1*r2 + c2) mod RLWE_Q, evaluated at full width
package ringlwe_pkg;

  localparam int RLWE_N = 4;
  localparam int RLWE_Q = 2;

  typedef logic [RLWE_Q-1:0] coef_t;
  typedef coef_t [RLWE_N-1:0] poly_t;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    IDLE  = 2'd1,
    BUSY  = 2'd2
  } state_t;

  // Modulus widened to the sum width so the remainder is taken without
  // truncating the intermediate result.
  localparam logic [2*RLWE_Q:0] MOD_W = (2*RLWE_Q+1)'(RLWE_Q);

  // Product kept at 2Q bits and the sum at 2Q+1 bits so nothing wraps
  // before the reduction; the remainder is always below Q and fits coef_t.
  function automatic coef_t coef_mac_mod(input coef_t c1, input coef_t r2,
                                         input coef_t c2);
    logic [2*RLWE_Q-1:0] prod;
    logic [2*RLWE_Q:0]   sum;
    logic [2*RLWE_Q:0]   rem;
    prod = {{RLWE_Q{1'b0}}, c1} * {{RLWE_Q{1'b0}}, r2};
    sum  = {1'b0, prod} + {{(RLWE_Q+1){1'b0}}, c2};
    rem  = sum % MOD_W;
    return rem[RLWE_Q-1:0];
  endfunction

endpackage

// File: rtl/ringlwe_coef_mac.sv
// ringlwe_coef_mac
// Combinational decode of one coefficient: m = (c1*r2 + c2) mod Q.
//   c1 : ciphertext coefficient of c1
//   r2 : private key (degree-0 polynomial)
//   c2 : ciphertext coefficient of c2
//   m  : decoded message coefficient
module ringlwe_coef_mac
  import ringlwe_pkg::*;
(
  input  coef_t c1,
  input  coef_t r2,
  input  coef_t c2,
  output coef_t m
);

  assign m = coef_mac_mod(c1, r2, c2);

endmodule

// File: rtl/ringlwe_decryptor.sv
// ringlwe_decryptor
// Streaming Ring-LWE decryption. Holds r2, decodes one ciphertext coefficient
// pair per accepted beat into a registered output stream and assembles the
// decoded polynomial.
//   clk, rst_n              : clock, asynchronous active-low reset
//   key_load, key_r2        : key load strobe and key value
//   key_loaded              : a key is present
//   ct_valid/ct_ready       : ciphertext stream handshake
//   ct_c1, ct_c2, ct_last   : ciphertext coefficient pair, sender end marker
//   msg_valid/msg_ready     : message stream handshake
//   msg_coef, msg_index     : decoded coefficient and its index
//   msg_last                : msg_index == N-1
//   decoded_message         : assembled polynomial, index i at [i]
//   done                    : one-cycle pulse per completed polynomial
//   frame_err               : sticky framing error (cleared by a key load)
module ringlwe_decryptor
  import ringlwe_pkg::*;
#(
  parameter int N  = RLWE_N,
  parameter int Q  = RLWE_Q,
  localparam int IW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_load,
  input  logic [Q-1:0]          key_r2,
  output logic                  key_loaded,
  input  logic                  ct_valid,
  output logic                  ct_ready,
  input  logic [Q-1:0]          ct_c1,
  input  logic [Q-1:0]          ct_c2,
  input  logic                  ct_last,
  output logic                  msg_valid,
  input  logic                  msg_ready,
  output logic [Q-1:0]          msg_coef,
  output logic [IW-1:0]         msg_index,
  output logic                  msg_last,
  output logic [N-1:0][Q-1:0]   decoded_message,
  output logic                  done,
  output logic                  frame_err
);

  state_t        state_reg, state_next;
  logic [IW-1:0] cnt_reg, cnt_next;
  logic [Q-1:0]  r2_reg;
  logic          load_key;
  logic          ct_hs;
  logic          msg_hs;
  logic          at_last;
  logic [Q-1:0]  mac_res;

  assign key_loaded = (state_reg != NOKEY);
  assign at_last    = (cnt_reg == IW'(N-1));

  // A key load in IDLE owns the cycle, and a full output register that the
  // sink is not draining blocks new beats so nothing is overwritten.
  assign ct_ready = key_loaded && !(state_reg == IDLE && key_load) &&
                    (!msg_valid || msg_ready);
  assign ct_hs    = ct_valid && ct_ready;
  assign msg_hs   = msg_valid && msg_ready;

  ringlwe_coef_mac u_mac (
    .c1 (ct_c1),
    .r2 (r2_reg),
    .c2 (ct_c2),
    .m  (mac_res)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_key   = 1'b0;
    case (state_reg)
      NOKEY: begin
        if (key_load) begin
          load_key   = 1'b1;
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (key_load) begin
          load_key = 1'b1;
        end else if (ct_hs) begin
          cnt_next   = cnt_reg + 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // key_load deliberately ignored mid-frame
        if (ct_hs) begin
          if (at_last) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= NOKEY;
      cnt_reg   <= '0;
      r2_reg    <= '0;
      frame_err <= 1'b0;
      msg_valid <= 1'b0;
      msg_coef  <= '0;
      msg_index <= '0;
      msg_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (load_key) begin
        r2_reg <= key_r2;
      end

      // Framing is judged purely by the count; the stream keeps decoding.
      if (load_key) begin
        frame_err <= 1'b0;
      end else if (ct_hs && (ct_last != at_last)) begin
        frame_err <= 1'b1;
      end

      // A new beat takes precedence over the drain so that a simultaneous
      // drain and accept keeps msg_valid high at full rate.
      if (ct_hs) begin
        msg_valid <= 1'b1;
        msg_coef  <= mac_res;
        msg_index <= cnt_reg;
        msg_last  <= at_last;
      end else if (msg_hs) begin
        msg_valid <= 1'b0;
      end

      // Coincides with the final beat of a frame appearing on the output.
      done <= ct_hs && at_last;
    end
  end

  // Each slot only changes when its own index is accepted, so untouched
  // slots keep the previous frame's value.
  for (genvar gi = 0; gi < N; gi++) begin : g_assemble
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        decoded_message[gi] <= '0;
      end else if (ct_hs && (cnt_reg == IW'(gi))) begin
        decoded_message[gi] <= mac_res;
      end
    end
  end

endmodule

// File: tb/tb_ringlwe_decryptor.sv
// tb_ringlwe_decryptor
// Scoreboard bench: expected beats are queued when a ciphertext handshake is
// seen and compared when the DUT's message handshake occurs.
module tb_ringlwe_decryptor;

  localparam int N  = 4;
  localparam int Q  = 2;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               key_load = 1'b0;
  logic [Q-1:0]       key_r2 = '0;
  logic               key_loaded;
  logic               ct_valid = 1'b0;
  logic               ct_ready;
  logic [Q-1:0]       ct_c1 = '0;
  logic [Q-1:0]       ct_c2 = '0;
  logic               ct_last = 1'b0;
  logic               msg_valid;
  logic               msg_ready = 1'b1;
  logic [Q-1:0]       msg_coef;
  logic [IW-1:0]      msg_index;
  logic               msg_last;
  logic [N-1:0][Q-1:0] decoded_message;
  logic               done;
  logic               frame_err;

  always #5 clk = ~clk;

  ringlwe_decryptor #(.N(N), .Q(Q)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_load        (key_load),
    .key_r2          (key_r2),
    .key_loaded      (key_loaded),
    .ct_valid        (ct_valid),
    .ct_ready        (ct_ready),
    .ct_c1           (ct_c1),
    .ct_c2           (ct_c2),
    .ct_last         (ct_last),
    .msg_valid       (msg_valid),
    .msg_ready       (msg_ready),
    .msg_coef        (msg_coef),
    .msg_index       (msg_index),
    .msg_last        (msg_last),
    .decoded_message (decoded_message),
    .done            (done),
    .frame_err       (frame_err)
  );

  typedef struct {
    int coef;
    int idx;
    bit last;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int mr2 = 0;
  bit mkey = 0;
  int mcnt = 0;
  bit merr = 0;
  int mdec[N];
  int exp_frames = 0;
  int done_seen = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  function automatic logic [N*Q-1:0] pack_model();
    logic [N*Q-1:0] p;
    int v;
    p = '0;
    for (int i = 0; i < N; i++) begin
      v = mdec[i];
      p[i*Q +: Q] = v[Q-1:0];
    end
    return p;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: message handshakes happen at the next rising edge; inputs only
  // change just after rising edges, so the falling edge sees stable values.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      exp_t e;
      if (done) done_seen++;
      if (msg_valid && msg_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("coef", 64'(msg_coef), 64'(e.coef));
          chk("index", 64'(msg_index), 64'(e.idx));
          chk("last", 64'(msg_last), 64'(e.last));
        end
      end
    end
  end

  task automatic send(input int c1, input int c2, input bit last);
    int t;
    exp_t e;
    bit ok;
    ct_valid = 1'b1;
    ct_c1 = c1[Q-1:0];
    ct_c2 = c2[Q-1:0];
    ct_last = last;
    t = 0;
    ok = 0;
    while (!ok && t < 50) begin
      @(negedge clk);
      if (ct_ready) ok = 1;
      t++;
    end
    if (!ok) begin
      chk("ct_timeout", 64'd0, 64'd1);
    end else begin
      e.coef = (c1 * mr2 + c2) % Q;
      e.idx  = mcnt;
      e.last = (mcnt == N-1);
      sb.push_back(e);
      mdec[mcnt] = e.coef;
      if ((mcnt == N-1) != last) merr = 1;
      if (mcnt == N-1) exp_frames++;
      mcnt = (mcnt + 1) % N;
    end
    @(posedge clk);
    #1;
    ct_valid = 1'b0;
    ct_last = 1'b0;
  endtask

  task automatic load(input int v);
    key_load = 1'b1;
    key_r2 = v[Q-1:0];
    @(negedge clk);
    if (mcnt == 0) chk("ready_during_load", 64'(ct_ready), 64'd0);
    @(posedge clk);
    #1;
    key_load = 1'b0;
    if (mcnt == 0) begin
      mr2 = v;
      mkey = 1;
      merr = 0;
    end
    chk("key_loaded", 64'(key_loaded), 64'(mkey));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key_loaded"}, 64'(key_loaded), 64'd0);
    chk({tag, "_ct_ready"}, 64'(ct_ready), 64'd0);
    chk({tag, "_msg_valid"}, 64'(msg_valid), 64'd0);
    chk({tag, "_msg_coef"}, 64'(msg_coef), 64'd0);
    chk({tag, "_msg_index"}, 64'(msg_index), 64'd0);
    chk({tag, "_msg_last"}, 64'(msg_last), 64'd0);
    chk({tag, "_decoded"}, 64'(decoded_message), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < N; i++) mdec[i] = 0;

    // Reset, then offer a beat with no key present.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ct_valid = 1'b1;
    @(negedge clk);
    chk_reset_outputs("nokey");
    @(posedge clk);
    #1;
    ct_valid = 1'b0;
    load(1);

    // Basic frame at full rate.
    msg_ready = 1'b1;
    c0 = cyc;
    send(1, 0, 0);
    send(0, 1, 0);
    send(1, 1, 0);
    send(1, 0, 1);
    chk("rate_t2", 64'(cyc - c0), 64'd4);
    drain();
    chk("dec_t2_const", 64'(decoded_message), 64'h45);
    chk("dec_t2", 64'(decoded_message), 64'(pack_model()));
    chk("ferr_t2", 64'(frame_err), 64'(merr));
    chk("done_t2", 64'(done_seen), 64'(exp_frames));

    // Key 3, then key 0.
    load(3);
    send(3, 2, 0);
    send(1, 1, 0);
    send(2, 3, 0);
    send(3, 0, 1);
    drain();
    load(0);
    send(1, 0, 0);
    send(2, 1, 0);
    send(3, 3, 0);
    send(0, 2, 1);
    drain();
    chk("dec_t3", 64'(decoded_message), 64'(pack_model()));

    // Backpressure mid-frame.
    load(1);
    send(1, 0, 0);
    send(0, 1, 0);
    msg_ready = 1'b0;
    fork
      send(1, 1, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready", 64'(ct_ready), 64'd0);
          chk("stall_index", 64'(msg_index), 64'd1);
          chk("stall_coef", 64'(msg_coef), 64'd1);
        end
        @(posedge clk);
        #1;
        msg_ready = 1'b1;
      end
    join
    send(1, 1, 1);
    c0 = cyc;
    send(0, 0, 0);
    send(1, 0, 0);
    send(0, 1, 0);
    send(1, 1, 1);
    chk("rate_t4", 64'(cyc - c0), 64'd4);
    drain();
    chk("dec_t4", 64'(decoded_message), 64'(pack_model()));

    // Framing errors.
    send(1, 0, 0);
    send(1, 0, 1);
    chk("ferr_early_last", 64'(frame_err), 64'(merr));
    send(1, 1, 0);
    send(1, 1, 1);
    drain();
    send(0, 1, 0);
    send(1, 1, 0);
    send(0, 0, 0);
    send(1, 0, 1);
    drain();
    chk("ferr_sticky", 64'(frame_err), 64'(merr));
    chk("dec_t5", 64'(decoded_message), 64'(pack_model()));
    load(1);
    chk("ferr_cleared", 64'(frame_err), 64'(merr));
    send(1, 0, 0);
    send(1, 0, 0);
    send(1, 0, 0);
    send(1, 0, 0);
    drain();
    chk("ferr_missing_last", 64'(frame_err), 64'(merr));
    load(1);
    chk("ferr_cleared2", 64'(frame_err), 64'(merr));

    // Key load mid-frame is ignored.
    send(1, 0, 0);
    send(1, 1, 0);
    load(0);
    send(1, 0, 0);
    send(1, 1, 1);
    drain();
    chk("dec_t6", 64'(decoded_message), 64'(pack_model()));
    chk("done_t6", 64'(done_seen), 64'(exp_frames));

    // Reset mid-frame.
    send(1, 0, 0);
    send(1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    mcnt = 0;
    mkey = 0;
    mr2 = 0;
    merr = 0;
    for (int i = 0; i < N; i++) mdec[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load(1);
    send(0, 1, 0);
    send(1, 1, 0);
    send(1, 0, 0);
    send(0, 0, 1);
    drain();
    chk("dec_final", 64'(decoded_message), 64'(pack_model()));
    chk("done_final", 64'(done_seen), 64'(exp_frames));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
